// File: rtl/frame_buffer_sched_if.sv
// Frame-buffer scheduler bus: writer/reader events in, buffer roles out.
//
// Handshake: there is no valid/ready pair. wr_done and rd_req are single-cycle
// pulses from the master that are always accepted. Every rd_req is answered by
// an rd_ack pulse exactly one cycle later. rd_new is meaningful only while
// rd_ack is high. wr_buf/rd_buf and their bases are level outputs that change
// only on the edge that applies an event. dbg_* expose the internal third
// buffer and its pending flag so that checkers can observe the buffer roles.
interface frame_buffer_sched_if #(
    parameter int AW = 18
);
    logic          wr_done;
    logic          rd_req;
    logic [1:0]    wr_buf;
    logic [AW-1:0] wr_base;
    logic [1:0]    rd_buf;
    logic [AW-1:0] rd_base;
    logic          rd_ack;
    logic          rd_new;
    logic [7:0]    drop_cnt;
    logic [7:0]    rep_cnt;
    logic          dbg_pend_valid;
    logic [1:0]    dbg_third_buf;

    // The scheduler side
    modport slave (
        input  wr_done, rd_req,
        output wr_buf, wr_base, rd_buf, rd_base, rd_ack, rd_new,
        output drop_cnt, rep_cnt, dbg_pend_valid, dbg_third_buf
    );

    // The writer/reader side
    modport master (
        output wr_done, rd_req,
        input  wr_buf, wr_base, rd_buf, rd_base, rd_ack, rd_new,
        input  drop_cnt, rep_cnt, dbg_pend_valid, dbg_third_buf
    );
endinterface

// File: rtl/frame_buffer_sched.sv
// Double/triple frame-buffer role scheduler. The module tracks which frame-store
// buffer the writer fills and which buffer the reader scans, and it counts
// dropped and repeated frames. When wr_done and rd_req arrive in the same cycle,
// the write completion is applied first and the read request sees the result.
module frame_buffer_sched #(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240,
    parameter int AW     = $clog2(3*WIDTH*HEIGHT)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 triple,
    frame_buffer_sched_if.slave  bus
);

    localparam logic [AW-1:0] BASE0 = '0;
    localparam logic [AW-1:0] BASE1 = AW'(WIDTH*HEIGHT);
    localparam logic [AW-1:0] BASE2 = AW'(2*WIDTH*HEIGHT);

    // Frame-store base address of a buffer index, computed at AW bits
    function automatic logic [AW-1:0] base_of(input logic [1:0] idx);
        case (idx)
            2'd0:    base_of = BASE0;
            2'd1:    base_of = BASE1;
            2'd2:    base_of = BASE2;
            default: base_of = BASE0;
        endcase
    endfunction

    // Mode capture: the mode is taken once, on the first edge after reset
    logic          latched_q, latched_d;
    logic          mode_q, mode_d;
    // Buffer roles
    logic [1:0]    wr_buf_q, wr_buf_d;
    logic [1:0]    rd_buf_q, rd_buf_d;
    logic [1:0]    pend_buf_q, pend_buf_d;
    logic [1:0]    free_buf_q, free_buf_d;
    logic          pend_valid_q, pend_valid_d;
    logic          fresh_q, fresh_d;
    // Registered outputs
    logic          rd_ack_q, rd_ack_d;
    logic          rd_new_q, rd_new_d;
    logic [7:0]    drop_cnt_q, drop_cnt_d;
    logic [7:0]    rep_cnt_q, rep_cnt_d;
    logic [AW-1:0] wr_base_q, wr_base_d;
    logic [AW-1:0] rd_base_q, rd_base_d;

    // Next-state: apply wr_done first, then rd_req on the updated roles
    always_comb begin
        latched_d    = 1'b1;
        mode_d       = latched_q ? mode_q : triple;
        wr_buf_d     = wr_buf_q;
        rd_buf_d     = rd_buf_q;
        pend_buf_d   = pend_buf_q;
        free_buf_d   = free_buf_q;
        pend_valid_d = pend_valid_q;
        fresh_d      = fresh_q;
        drop_cnt_d   = drop_cnt_q;
        rep_cnt_d    = rep_cnt_q;
        rd_ack_d     = bus.rd_req;
        rd_new_d     = 1'b0;

        // Writer finished a frame
        if (bus.wr_done) begin
            if (mode_d) begin
                if (!pend_valid_q) begin
                    // Completed frame becomes pending; writer moves to the free buffer
                    pend_buf_d   = wr_buf_q;
                    wr_buf_d     = free_buf_q;
                    free_buf_d   = pend_buf_q;
                    pend_valid_d = 1'b1;
                end else begin
                    // The older pending frame is overwritten without being read
                    pend_buf_d = wr_buf_q;
                    wr_buf_d   = pend_buf_q;
                    if (drop_cnt_q != 8'hFF) begin
                        drop_cnt_d = drop_cnt_q + 8'd1;
                    end
                end
            end else begin
                // Double buffering: writer and reader trade buffers
                wr_buf_d = rd_buf_q;
                rd_buf_d = wr_buf_q;
                fresh_d  = 1'b1;
            end
        end

        // Reader starts a frame; it sees the roles after any wr_done above
        if (bus.rd_req) begin
            if (mode_d) begin
                if (pend_valid_d) begin
                    free_buf_d   = rd_buf_d;
                    rd_buf_d     = pend_buf_d;
                    pend_valid_d = 1'b0;
                    rd_new_d     = 1'b1;
                end else if (rep_cnt_q != 8'hFF) begin
                    rep_cnt_d = rep_cnt_q + 8'd1;
                end
            end else begin
                rd_new_d = fresh_d;
                if (!fresh_d && rep_cnt_q != 8'hFF) begin
                    rep_cnt_d = rep_cnt_q + 8'd1;
                end
                fresh_d = 1'b0;
            end
        end

        wr_base_d = base_of(wr_buf_d);
        rd_base_d = base_of(rd_buf_d);
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            latched_q    <= 1'b0;
            mode_q       <= 1'b0;
            wr_buf_q     <= 2'd0;
            rd_buf_q     <= 2'd1;
            pend_buf_q   <= 2'd2;
            free_buf_q   <= 2'd2;
            pend_valid_q <= 1'b0;
            fresh_q      <= 1'b0;
            rd_ack_q     <= 1'b0;
            rd_new_q     <= 1'b0;
            drop_cnt_q   <= 8'd0;
            rep_cnt_q    <= 8'd0;
            wr_base_q    <= BASE0;
            rd_base_q    <= BASE1;
        end else begin
            latched_q    <= latched_d;
            mode_q       <= mode_d;
            wr_buf_q     <= wr_buf_d;
            rd_buf_q     <= rd_buf_d;
            pend_buf_q   <= pend_buf_d;
            free_buf_q   <= free_buf_d;
            pend_valid_q <= pend_valid_d;
            fresh_q      <= fresh_d;
            rd_ack_q     <= rd_ack_d;
            rd_new_q     <= rd_new_d;
            drop_cnt_q   <= drop_cnt_d;
            rep_cnt_q    <= rep_cnt_d;
            wr_base_q    <= wr_base_d;
            rd_base_q    <= rd_base_d;
        end
    end

    // Drive the bus from registers only
    always_comb begin
        bus.wr_buf         = wr_buf_q;
        bus.wr_base        = wr_base_q;
        bus.rd_buf         = rd_buf_q;
        bus.rd_base        = rd_base_q;
        bus.rd_ack         = rd_ack_q;
        bus.rd_new         = rd_new_q;
        bus.drop_cnt       = drop_cnt_q;
        bus.rep_cnt        = rep_cnt_q;
        bus.dbg_pend_valid = pend_valid_q;
        bus.dbg_third_buf  = pend_valid_q ? pend_buf_q : free_buf_q;
    end

endmodule

// File: tb/tb_frame_buffer_sched.sv
// Directed bench for frame_buffer_sched: triple and double buffering, coincident
// events, counter saturation and asynchronous reset mid-sequence.
module tb_frame_buffer_sched;

    localparam int WIDTH  = 320;
    localparam int HEIGHT = 240;
    localparam int AW     = 18;
    localparam int B1     = 76800;
    localparam int B2     = 153600;

    logic clk;
    logic reset_n;
    logic triple;
    int   n_checks;
    int   n_errs;

    frame_buffer_sched_if #(.AW(AW)) bus ();

    frame_buffer_sched #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .triple  (triple),
        .bus     (bus)
    );

    // Clock: 10 ns period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errs++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock with the given event pulses; returns 1 ns after the edge
    task automatic step(input logic wd, input logic rq);
        bus.wr_done = wd;
        bus.rd_req  = rq;
        @(posedge clk);
        #1;
        bus.wr_done = 1'b0;
        bus.rd_req  = 1'b0;
    endtask

    // All outputs at their reset values
    task automatic chk_reset(input string tag);
        chk({tag, ".wr_buf"},   32'(bus.wr_buf), 0);
        chk({tag, ".rd_buf"},   32'(bus.rd_buf), 1);
        chk({tag, ".wr_base"},  32'(bus.wr_base), 0);
        chk({tag, ".rd_base"},  32'(bus.rd_base), B1);
        chk({tag, ".rd_ack"},   32'(bus.rd_ack), 0);
        chk({tag, ".rd_new"},   32'(bus.rd_new), 0);
        chk({tag, ".drop_cnt"}, 32'(bus.drop_cnt), 0);
        chk({tag, ".rep_cnt"},  32'(bus.rep_cnt), 0);
        chk({tag, ".pend_v"},   32'(bus.dbg_pend_valid), 0);
        chk({tag, ".third"},    32'(bus.dbg_third_buf), 2);
    endtask

    // Reset with the given mode, check reset values, release away from an edge
    task automatic do_reset(input logic t, input string tag);
        reset_n     = 1'b0;
        triple      = t;
        bus.wr_done = 1'b0;
        bus.rd_req  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset(tag);
        reset_n = 1'b1;
    endtask

    // Triple-mode roles must stay pairwise distinct
    task automatic chk_distinct(input string tag);
        chk(tag, 32'((bus.wr_buf != bus.rd_buf) && (bus.wr_buf != bus.dbg_third_buf)
                     && (bus.rd_buf != bus.dbg_third_buf) && (bus.wr_buf < 2'd3)
                     && (bus.rd_buf < 2'd3) && (bus.dbg_third_buf < 2'd3)), 1);
    endtask

    initial begin
        n_checks    = 0;
        n_errs      = 0;
        reset_n     = 1'b0;
        triple      = 1'b1;
        bus.wr_done = 1'b0;
        bus.rd_req  = 1'b0;

        // ---- Triple: one wr_done then rd_req ----
        do_reset(1'b1, "a_rst");
        step(1'b1, 1'b0);
        chk("a_wd.wr_buf", 32'(bus.wr_buf), 2);
        chk("a_wd.wr_base", 32'(bus.wr_base), B2);
        chk("a_wd.pend_v", 32'(bus.dbg_pend_valid), 1);
        chk("a_wd.third", 32'(bus.dbg_third_buf), 0);
        chk("a_wd.rd_ack", 32'(bus.rd_ack), 0);
        step(1'b0, 1'b1);
        chk("a_rd.rd_ack", 32'(bus.rd_ack), 1);
        chk("a_rd.rd_buf", 32'(bus.rd_buf), 0);
        chk("a_rd.rd_new", 32'(bus.rd_new), 1);
        chk("a_rd.rd_base", 32'(bus.rd_base), 0);
        chk("a_rd.wr_buf", 32'(bus.wr_buf), 2);
        chk("a_rd.third", 32'(bus.dbg_third_buf), 1);
        step(1'b0, 1'b0);
        chk("a_idle.rd_ack", 32'(bus.rd_ack), 0);

        // ---- Triple: three wr_done, then reads ----
        do_reset(1'b1, "b_rst");
        step(1'b1, 1'b0);
        chk("b_wd1.wr_buf", 32'(bus.wr_buf), 2);
        chk("b_wd1.drop", 32'(bus.drop_cnt), 0);
        chk_distinct("b_wd1.distinct");
        step(1'b1, 1'b0);
        chk("b_wd2.wr_buf", 32'(bus.wr_buf), 0);
        chk("b_wd2.wr_base", 32'(bus.wr_base), 0);
        chk("b_wd2.third", 32'(bus.dbg_third_buf), 2);
        chk("b_wd2.drop", 32'(bus.drop_cnt), 1);
        chk_distinct("b_wd2.distinct");
        step(1'b1, 1'b0);
        chk("b_wd3.wr_buf", 32'(bus.wr_buf), 2);
        chk("b_wd3.drop", 32'(bus.drop_cnt), 2);
        chk_distinct("b_wd3.distinct");
        step(1'b0, 1'b1);
        chk("b_rd1.rd_ack", 32'(bus.rd_ack), 1);
        chk("b_rd1.rd_new", 32'(bus.rd_new), 1);
        chk("b_rd1.rd_buf", 32'(bus.rd_buf), 0);
        chk("b_rd1.rep", 32'(bus.rep_cnt), 0);
        chk_distinct("b_rd1.distinct");
        // back-to-back reads with nothing pending
        step(1'b0, 1'b1);
        chk("b_rd2.rd_ack", 32'(bus.rd_ack), 1);
        chk("b_rd2.rd_new", 32'(bus.rd_new), 0);
        chk("b_rd2.rep", 32'(bus.rep_cnt), 1);
        step(1'b0, 1'b1);
        chk("b_rd3.rd_ack", 32'(bus.rd_ack), 1);
        chk("b_rd3.rep", 32'(bus.rep_cnt), 2);
        chk("b_rd3.rd_buf", 32'(bus.rd_buf), 0);
        step(1'b0, 1'b0);
        chk("b_idle.rd_ack", 32'(bus.rd_ack), 0);

        // ---- Triple: coincident wr_done and rd_req from reset ----
        do_reset(1'b1, "c_rst");
        step(1'b1, 1'b1);
        chk("c_co.rd_ack", 32'(bus.rd_ack), 1);
        chk("c_co.rd_buf", 32'(bus.rd_buf), 0);
        chk("c_co.rd_new", 32'(bus.rd_new), 1);
        chk("c_co.drop", 32'(bus.drop_cnt), 0);
        chk("c_co.wr_buf", 32'(bus.wr_buf), 2);
        chk("c_co.rd_base", 32'(bus.rd_base), 0);
        chk("c_co.third", 32'(bus.dbg_third_buf), 1);
        step(1'b1, 1'b0);
        chk("c_wd.wr_buf", 32'(bus.wr_buf), 1);
        chk("c_wd.wr_base", 32'(bus.wr_base), B1);
        chk("c_wd.third", 32'(bus.dbg_third_buf), 2);
        step(1'b0, 1'b1);
        chk("c_rd.rd_buf", 32'(bus.rd_buf), 2);
        chk("c_rd.rd_base", 32'(bus.rd_base), B2);
        chk("c_rd.rd_new", 32'(bus.rd_new), 1);
        chk("c_rd.third", 32'(bus.dbg_third_buf), 0);
        chk_distinct("c_rd.distinct");

        // ---- Double mode; triple raised after latching must be ignored ----
        do_reset(1'b0, "d_rst");
        step(1'b0, 1'b0);
        triple = 1'b1;
        step(1'b0, 1'b1);
        chk("d_rd1.rd_new", 32'(bus.rd_new), 0);
        chk("d_rd1.rep", 32'(bus.rep_cnt), 1);
        chk("d_rd1.rd_buf", 32'(bus.rd_buf), 1);
        step(1'b0, 1'b1);
        chk("d_rd2.rep", 32'(bus.rep_cnt), 2);
        chk("d_rd2.rd_ack", 32'(bus.rd_ack), 1);
        step(1'b1, 1'b0);
        chk("d_wd.wr_buf", 32'(bus.wr_buf), 1);
        chk("d_wd.rd_buf", 32'(bus.rd_buf), 0);
        chk("d_wd.wr_base", 32'(bus.wr_base), B1);
        chk("d_wd.rd_base", 32'(bus.rd_base), 0);
        step(1'b0, 1'b1);
        chk("d_rd3.rd_new", 32'(bus.rd_new), 1);
        chk("d_rd3.rep", 32'(bus.rep_cnt), 2);
        chk("d_rd3.rd_buf", 32'(bus.rd_buf), 0);
        step(1'b0, 1'b1);
        chk("d_rd4.rd_new", 32'(bus.rd_new), 0);
        chk("d_rd4.rep", 32'(bus.rep_cnt), 3);
        step(1'b1, 1'b1);
        chk("d_co.rd_new", 32'(bus.rd_new), 1);
        chk("d_co.rd_buf", 32'(bus.rd_buf), 1);
        chk("d_co.wr_buf", 32'(bus.wr_buf), 0);
        chk("d_co.rep", 32'(bus.rep_cnt), 3);
        chk("d_co.drop", 32'(bus.drop_cnt), 0);

        // ---- Repeat counter saturation and mid-sequence reset ----
        do_reset(1'b1, "e_rst");
        for (int i = 1; i <= 300; i++) begin
            step(1'b0, 1'b1);
            if (i == 100) chk("e_rep100", 32'(bus.rep_cnt), 100);
            if (i == 255) chk("e_rep255", 32'(bus.rep_cnt), 255);
            if (i == 256) chk("e_rep256", 32'(bus.rep_cnt), 255);
        end
        chk("e_rep300", 32'(bus.rep_cnt), 255);
        chk("e_ack300", 32'(bus.rd_ack), 1);
        // reset lands while an rd_ack is being shown
        #1;
        reset_n = 1'b0;
        #1;
        chk_reset("e_async");
        @(posedge clk);
        #1;
        chk("e_hold.rd_ack", 32'(bus.rd_ack), 0);
        chk("e_hold.rep", 32'(bus.rep_cnt), 0);
        reset_n = 1'b1;
        step(1'b0, 1'b0);
        chk("e_rel.rd_ack", 32'(bus.rd_ack), 0);
        chk("e_rel.rep", 32'(bus.rep_cnt), 0);
        chk("e_rel.rd_buf", 32'(bus.rd_buf), 1);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
